// File: rtl/core_irq_router_pkg.sv
// Shared definitions for the core interrupt router.
//   - register offsets of the configuration port
//   - upper bounds for the source / output counts
//   - register-select encoding used by the address decoder
//   - route field width helper: max(1, clog2(num_out))
package core_irq_router_pkg;

  localparam int unsigned MaxNumSrc = 32;
  localparam int unsigned MaxNumOut = 32;

  localparam logic [7:0] IrqRegEnable    = 8'h00;
  localparam logic [7:0] IrqRegMode      = 8'h04;
  localparam logic [7:0] IrqRegPolarity  = 8'h08;
  localparam logic [7:0] IrqRegPending   = 8'h0C;
  localparam logic [7:0] IrqRegRouteBase = 8'h40;

  typedef enum logic [2:0] {
    RegEnable,
    RegMode,
    RegPolarity,
    RegPending,
    RegRoute,
    RegNone
  } reg_sel_e;

  function automatic int unsigned route_width(input int unsigned num_out);
    return (num_out > 1) ? $clog2(num_out) : 1;
  endfunction

endpackage

// File: rtl/core_irq_gateway.sv
// Per-source interrupt conditioning: polarity, edge detect and pending latch.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   src_i         : raw source, synchronous to clk_i
//   mode_i        : 1 = edge, 0 = level
//   polarity_i    : 1 = active-low
//   clr_i         : write-1-to-clear strobe (edge mode only)
//   pending_o     : pending flag
module core_irq_gateway (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  input  logic mode_i,
  input  logic polarity_i,
  input  logic clr_i,
  output logic pending_o
);

  logic act;
  logic prev_d, prev_q;
  logic pending_d, pending_q;

  assign act = src_i ^ polarity_i;

  // In edge mode a new edge wins over a same-cycle clear.
  always_comb begin
    prev_d = act;
    if (mode_i) begin
      pending_d = (act & ~prev_q) | (pending_q & ~clr_i);
    end else begin
      pending_d = act;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/core_irq_router.sv
// Interrupt router: conditions NumSrc peripheral interrupts and routes each
// to one of NumOut core interrupt lines.
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   src_i                : raw interrupt sources
//   irq_o                : core interrupt lines
//   req_i/gnt_o/we_i     : register port request, grant, write enable
//   addr_i/wdata_i       : byte address, write data
//   rvalid_o/rdata_o/err_o : response one cycle after grant
module core_irq_router
  import core_irq_router_pkg::*;
#(
  parameter int unsigned NumSrc = 16,
  parameter int unsigned NumOut = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumSrc-1:0] src_i,
  output logic [NumOut-1:0] irq_o,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic              we_i,
  input  logic [7:0]        addr_i,
  input  logic [31:0]       wdata_i,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o
);

  localparam int unsigned RouteW = route_width(NumOut);

  logic [NumSrc-1:0] enable_d, enable_q;
  logic [NumSrc-1:0] mode_d, mode_q;
  logic [NumSrc-1:0] polarity_d, polarity_q;
  logic [RouteW-1:0] route_d [NumSrc];
  logic [RouteW-1:0] route_q [NumSrc];
  logic              rvalid_d, rvalid_q;
  logic              err_d, err_q;
  logic [31:0]       rdata_d, rdata_q;

  logic [NumSrc-1:0] pending;
  logic [NumSrc-1:0] clr;
  reg_sel_e          sel;
  logic [5:0]        route_word;
  logic [4:0]        route_idx;
  logic              acc_err;
  logic              wr_en;
  logic              unused_wdata;

  assign unused_wdata = ^wdata_i;
  assign gnt_o        = req_i;

  // Address decode. ROUTE slots beyond NumSrc are treated as unmapped.
  assign route_word = addr_i[7:2] - 6'd16;
  always_comb begin
    sel       = RegNone;
    route_idx = route_word[4:0];
    if (addr_i[1:0] == 2'b00) begin
      case (addr_i)
        IrqRegEnable:   sel = RegEnable;
        IrqRegMode:     sel = RegMode;
        IrqRegPolarity: sel = RegPolarity;
        IrqRegPending:  sel = RegPending;
        default: begin
          if (addr_i >= IrqRegRouteBase && 32'(route_word) < NumSrc) begin
            sel = RegRoute;
          end
        end
      endcase
    end
  end

  assign acc_err = (sel == RegNone);
  assign wr_en   = req_i & we_i & ~acc_err;

  always_comb begin
    enable_d   = enable_q;
    mode_d     = mode_q;
    polarity_d = polarity_q;
    route_d    = route_q;
    clr        = '0;
    if (wr_en) begin
      case (sel)
        RegEnable:   enable_d   = wdata_i[NumSrc-1:0];
        RegMode:     mode_d     = wdata_i[NumSrc-1:0];
        RegPolarity: polarity_d = wdata_i[NumSrc-1:0];
        RegPending:  clr        = wdata_i[NumSrc-1:0];
        RegRoute: begin
          for (int i = 0; i < NumSrc; i++) begin
            if (route_idx == 5'(i)) route_d[i] = wdata_i[RouteW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Read data is captured at the grant edge, so PENDING reads the
  // pre-update value.
  always_comb begin
    rvalid_d = req_i;
    err_d    = req_i & acc_err;
    rdata_d  = '0;
    if (req_i && !acc_err && !we_i) begin
      case (sel)
        RegEnable:   rdata_d = 32'(enable_q);
        RegMode:     rdata_d = 32'(mode_q);
        RegPolarity: rdata_d = 32'(polarity_q);
        RegPending:  rdata_d = 32'(pending);
        RegRoute: begin
          for (int i = 0; i < NumSrc; i++) begin
            if (route_idx == 5'(i)) rdata_d = 32'(route_q[i]);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      enable_q   <= '0;
      mode_q     <= '0;
      polarity_q <= '0;
      for (int i = 0; i < NumSrc; i++) route_q[i] <= RouteW'(i % NumOut);
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      polarity_q <= polarity_d;
      route_q    <= route_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

  for (genvar g = 0; g < NumSrc; g++) begin : g_gw
    core_irq_gateway u_gw (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .src_i      (src_i[g]),
      .mode_i     (mode_q[g]),
      .polarity_i (polarity_q[g]),
      .clr_i      (clr[g]),
      .pending_o  (pending[g])
    );
  end

  // Routing matrix; route values >= NumOut match no line.
  always_comb begin
    irq_o = '0;
    for (int i = 0; i < NumSrc; i++) begin
      for (int j = 0; j < NumOut; j++) begin
        if (pending[i] && enable_q[i] && route_q[i] == RouteW'(j)) irq_o[j] = 1'b1;
      end
    end
  end

endmodule
